// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch front end.
// Imported by the prefetch FIFO and the fetch unit top.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer of fetched words and their pcs.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch pc, issues credit-limited imem requests
// and hands {instr, pc} to decode through the prefetch FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] tag_pc;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic            fifo_full;
  logic            grant;
  logic            rsp;
  logic            accept;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign redirect_base = redirect_pc & ~32'h3;
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};

  assign imem_req  = n_rst && !redirect &&
                     (credit_used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // a response with nothing in flight is ignored
  assign grant  = imem_req && imem_gnt;
  assign rsp    = imem_rvalid && (outstanding != '0);
  assign accept = rsp && !redirect && (discard == '0);
  assign pop    = instr_valid && instr_ready && !redirect;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = tag_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (redirect),
    .push  (accept),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc    <= RESET_PC;
      tag_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (redirect) begin
        fetch_pc <= redirect_base;
        tag_pc   <= redirect_base;
        // every word still in flight after this cycle is stale
        discard  <= outstanding - CW'(rsp);
      end else begin
        if (grant)  fetch_pc <= fetch_pc + 32'd4;
        if (accept) tag_pc   <= tag_pc + 32'd4;
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!n_rst)
    imem_rvalid |-> (outstanding != '0));

  no_fifo_overflow: assert property (
    @(posedge clk) disable iff (!n_rst)
    accept |-> (!fifo_full || pop));

endmodule
